tx_subcarrier_mapper: RTL and testbench
=======================================

Name: tx_subcarrier_mapper

Overview:
- TX-side counterpart of the RX resource demapping index counter. It places modulated data symbols onto IFFT bins, inserting nulls (DC and guard band) and polarity-scrambled pilots.
- Walks bin index 0..N_FFT-1 in IFFT natural order, once per OFDM symbol, for a programmed number of symbols.
- Sits between the QAM mapper (upstream) and the IFFT input (downstream).

Parameters:
- N_FFT, 64, bins per OFDM symbol (power of 2).
- W, 16, bits per I and per Q component (signed).
- NULL_LO, 27, first guard-band null bin.
- NULL_HI, 37, last guard-band null bin (inclusive).
- P0/P1/P2/P3, 7/21/43/57, pilot bin indices. Base signs are +,+,+,−.
- PILOT_AMP, 16384, pilot real magnitude. Pilot imaginary part is always 0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  block enable; low = synchronous return to IDLE
- i_start  in  1  one-cycle pulse; starts a burst (honoured in IDLE only)
- i_num_sym  in  8  OFDM symbols in the burst, sampled on i_start
- i_data  in  2W  data symbol {I[2W-1:W], Q[W-1:0]}
- i_data_valid  in  1  upstream valid
- o_data_ready  out  1  upstream ready
- o_sym_data  out  2W  bin value to IFFT {I,Q}
- o_sym_valid  out  1  output valid
- i_ifft_ready  in  1  downstream ready
- o_bin_index  out  log2(N_FFT)  current bin index
- o_sym_start  out  1  o_sym_valid on bin 0
- o_sym_last  out  1  o_sym_valid on bin N_FFT-1
- o_busy  out  1  state == MAP
- o_done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset (async, i_rst_n low):
  - state IDLE; bin counter 0; symbol counter 0; LFSR 7'h7F.
  - All outputs 0.
- Bin class, combinational from the bin counter k:
  - NULL: k==0 or NULL_LO<=k<=NULL_HI.
  - PILOT: k in {P0..P3}.
  - DATA: all other bins (48 at defaults).
- FSM states:
  - IDLE: on i_start with i_enable, latch i_num_sym. Go to DONE if it is 0, else go to MAP with bin=0 and sym=0.
  - MAP, NULL or PILOT bin: o_sym_valid=1 unconditionally. o_sym_data = 0 (NULL) or pilot value (PILOT). o_data_ready=0.
  - MAP, DATA bin: o_sym_valid=i_data_valid; o_sym_data=i_data; o_data_ready=i_ifft_ready. This is a zero-latency pass-through; no upstream symbol is consumed on a non-DATA bin.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Advance rule: the bin advances only on o_sym_valid && i_ifft_ready. On a non-accepted cycle, all outputs hold stable.
- Wrap on accept at bin N_FFT-1:
  - bin wraps to 0; symbol counter increments; LFSR steps once.
  - If the symbol counter equals latched num_sym-1, go to DONE and clear both counters.
- Pilot polarity:
  - LFSR s[6:0], fb=s[6]^s[3], update s<={s[5:0],fb}, seed 7'h7F at burst start.
  - Current polarity bit = fb.
  - Pilot I = PILOT_AMP if (fb XOR base_sign_neg)==0, else −PILOT_AMP (two's complement, W bits).
  - The resulting sequence gives positive polarity for symbols 0-3 and negated polarity for symbol 4.
- o_bin_index equals the bin counter in all states; it is 0 outside MAP.
- o_sym_start and o_sym_last are qualified by o_sym_valid.
- i_start in MAP or DONE is ignored, and i_num_sym is not re-sampled.
- i_enable low in any state, next cycle:
  - state IDLE; counters 0; LFSR 7'h7F.
  - No o_done pulse; all valids/readies 0.
  - Any partial symbol is abandoned.
- Async reset mid-burst has the same result immediately.
- i_data_valid may toggle freely; the bench must not see bins skipped or reordered.

Test Plan:
- Reset then i_start with num_sym=1, data always valid (values 1..48), i_ifft_ready=1:
  - exactly 64 outputs; bins 0 and 27..37 are 0; bins 7/21/43 = +16384; bin 57 = −16384 (0xC000).
  - data bins carry 1..48 in order; o_done pulses the cycle after bin 63 is accepted.
- num_sym=6:
  - symbols 0-3 pilots {+,+,+,−}; symbol 4 pilots {−,−,−,+}.
  - o_sym_start/o_sym_last each pulse 6 times; one o_done.
- i_ifft_ready toggled every other cycle and i_data_valid randomly dropped:
  - output sequence identical to the stalled-free run.
  - o_data_ready never high on NULL/PILOT bins; outputs stable while stalled.
- i_start with num_sym=0 → o_done the next cycle, no o_sym_valid.
- i_start pulsed mid-burst → ignored; burst length is unchanged.
- i_enable dropped at bin 30 of symbol 2 → IDLE the next cycle, no o_done. A new burst restarts at bin 0 with LFSR 7'h7F (positive pilots).
- Async reset at the same point gives identical recovery.

Source files
------------

// File: rtl/tx_subcarrier_mapper.sv
// Places QAM data onto IFFT bins in natural order, inserting DC/guard nulls and polarity-scrambled pilots.
// Latency: zero; data bins are a combinational pass-through, nulls and pilots are generated in place.
// Backpressure: bin advances only on o_sym_valid && i_ifft_ready; o_data_ready follows i_ifft_ready on data bins only.
module tx_subcarrier_mapper #(
    parameter int N_FFT     = 64,
    parameter int W         = 16,
    parameter int NULL_LO   = 27,
    parameter int NULL_HI   = 37,
    parameter int P0        = 7,
    parameter int P1        = 21,
    parameter int P2        = 43,
    parameter int P3        = 57,
    parameter int PILOT_AMP = 16384
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_start,
    input  logic [7:0]                 i_num_sym,
    input  logic [2*W-1:0]             i_data,
    input  logic                       i_data_valid,
    output logic                       o_data_ready,
    output logic [2*W-1:0]             o_sym_data,
    output logic                       o_sym_valid,
    input  logic                       i_ifft_ready,
    output logic [$clog2(N_FFT)-1:0]   o_bin_index,
    output logic                       o_sym_start,
    output logic                       o_sym_last,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int BW = $clog2(N_FFT);
    localparam logic [BW-1:0] BIN_LAST  = BW'(N_FFT - 1);
    localparam logic [BW-1:0] BIN_NLO   = BW'(NULL_LO);
    localparam logic [BW-1:0] BIN_NHI   = BW'(NULL_HI);
    localparam logic [BW-1:0] BIN_P0    = BW'(P0);
    localparam logic [BW-1:0] BIN_P1    = BW'(P1);
    localparam logic [BW-1:0] BIN_P2    = BW'(P2);
    localparam logic [BW-1:0] BIN_P3    = BW'(P3);
    localparam logic [W-1:0]  PILOT_POS = W'(PILOT_AMP);
    localparam logic [W-1:0]  PILOT_NEG = W'(-PILOT_AMP);
    localparam logic [6:0]    LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  bin_q, bin_d;
    logic [7:0]     sym_q, sym_d;
    logic [7:0]     num_sym_q, num_sym_d;
    logic [6:0]     lfsr_q, lfsr_d;

    logic           is_null, is_pilot, is_data;
    logic           lfsr_fb, pilot_neg, in_map, accept;
    logic [W-1:0]   pilot_i;

    // Bin classification and pilot value; P3 carries the negative base sign.
    always_comb begin
        is_null   = (bin_q == '0) || ((bin_q >= BIN_NLO) && (bin_q <= BIN_NHI));
        is_pilot  = (bin_q == BIN_P0) || (bin_q == BIN_P1) ||
                    (bin_q == BIN_P2) || (bin_q == BIN_P3);
        is_data   = !is_null && !is_pilot;
        lfsr_fb   = lfsr_q[6] ^ lfsr_q[3];
        pilot_neg = lfsr_fb ^ (bin_q == BIN_P3);
        pilot_i   = pilot_neg ? PILOT_NEG : PILOT_POS;
    end

    assign in_map = (state_q == MAP);

    always_comb begin
        o_sym_valid  = 1'b0;
        o_sym_data   = '0;
        o_data_ready = 1'b0;
        if (in_map) begin
            if (is_data) begin
                o_sym_valid  = i_data_valid;
                o_sym_data   = i_data;
                o_data_ready = i_ifft_ready;
            end else begin
                o_sym_valid  = 1'b1;
                o_sym_data   = is_pilot ? {pilot_i, {W{1'b0}}} : '0;
            end
        end
    end

    assign accept      = o_sym_valid && i_ifft_ready;
    assign o_bin_index = bin_q;
    assign o_sym_start = o_sym_valid && (bin_q == '0);
    assign o_sym_last  = o_sym_valid && (bin_q == BIN_LAST);
    assign o_busy      = in_map;
    assign o_done      = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        sym_d     = sym_q;
        num_sym_d = num_sym_q;
        lfsr_d    = lfsr_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_sym_d = i_num_sym;
                    bin_d     = '0;
                    sym_d     = '0;
                    lfsr_d    = LFSR_SEED;
                    state_d   = (i_num_sym == 8'd0) ? DONE : MAP;
                end
            end
            MAP: begin
                if (accept) begin
                    if (bin_q == BIN_LAST) begin
                        bin_d  = '0;
                        lfsr_d = {lfsr_q[5:0], lfsr_fb};
                        if (sym_q == num_sym_q - 8'd1) begin
                            sym_d   = '0;
                            state_d = DONE;
                        end else begin
                            sym_d = sym_q + 8'd1;
                        end
                    end else begin
                        bin_d = bin_q + BW'(1);
                    end
                end
            end
            DONE: begin
                lfsr_d  = LFSR_SEED;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Disable wins over everything, abandoning any partial symbol without a done pulse.
        if (!i_enable) begin
            state_d = IDLE;
            bin_d   = '0;
            sym_d   = '0;
            lfsr_d  = LFSR_SEED;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            sym_q     <= '0;
            num_sym_q <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            sym_q     <= sym_d;
            num_sym_q <= num_sym_d;
            lfsr_q    <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_tx_subcarrier_mapper.sv
// Directed bench for tx_subcarrier_mapper: table of hand-computed bins plus multi-cycle corner sequences.
module tb_tx_subcarrier_mapper;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_start;
    logic [7:0]  i_num_sym;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [31:0] o_sym_data;
    logic        o_sym_valid;
    logic        i_ifft_ready;
    logic [5:0]  o_bin_index;
    logic        o_sym_start;
    logic        o_sym_last;
    logic        o_busy;
    logic        o_done;

    tx_subcarrier_mapper dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_start      (i_start),
        .i_num_sym    (i_num_sym),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_sym_data   (o_sym_data),
        .o_sym_valid  (o_sym_valid),
        .i_ifft_ready (i_ifft_ready),
        .o_bin_index  (o_bin_index),
        .o_sym_start  (o_sym_start),
        .o_sym_last   (o_sym_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          sym;
        int          bin;
        logic [15:0] ei;
        logic [15:0] eq;
    } vec_t;

    vec_t        tbl[18];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cap_dat[$];
    int          cap_bin[$];
    logic [31:0] ref_dat[$];
    int          n_start, n_last, n_done, viol;
    int          cyc = 0;
    int          last_acc_cyc, done_cyc, start_cyc;
    int          d;
    bit          stall_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat;
    int          prev_bin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_data_bin(input int b);
        return !(b == 0 || (b >= 27 && b <= 37) || b == 7 || b == 21 || b == 43 || b == 57);
    endfunction

    // Polarity bit for symbol s: LFSR seeded 7F, fb = s6^s3, stepped once per symbol.
    function automatic bit pol(input int s);
        logic [6:0] l;
        bit fb;
        l = 7'h7F;
        for (int j = 0; j < s; j++) begin
            fb = l[6] ^ l[3];
            l  = {l[5:0], fb};
        end
        return l[6] ^ l[3];
    endfunction

    task automatic tick();
        bit acc, dhs;
        @(negedge i_clk);
        cyc++;
        acc = o_sym_valid && i_ifft_ready;
        dhs = i_data_valid && o_data_ready;
        if (prev_stall && (!o_sym_valid || o_sym_data !== prev_dat || int'(o_bin_index) != prev_bin)) viol++;
        if (o_data_ready && !(o_busy && is_data_bin(int'(o_bin_index)))) viol++;
        if (o_sym_start && !(o_sym_valid && o_bin_index == 6'd0)) viol++;
        if (o_sym_last && !(o_sym_valid && o_bin_index == 6'd63)) viol++;
        if (!o_busy && (o_sym_valid || o_data_ready)) viol++;
        prev_stall = o_sym_valid && !i_ifft_ready;
        prev_dat   = o_sym_data;
        prev_bin   = int'(o_bin_index);
        if (acc) begin
            cap_dat.push_back(o_sym_data);
            cap_bin.push_back(int'(o_bin_index));
            if (o_sym_start) n_start++;
            if (o_sym_last) n_last++;
            last_acc_cyc = cyc;
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge i_clk);
        #1;
        if (dhs) d++;
        i_data = {d[15:0], 16'(d + 1000)};
        if (stall_mode) begin
            i_ifft_ready = ~i_ifft_ready;
            if (!(i_data_valid && !dhs)) i_data_valid = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic run_burst(input int n, input bit stall, input int mid_start, input int abort_at);
        cap_dat.delete();
        cap_bin.delete();
        n_start = 0; n_last = 0; n_done = 0; viol = 0;
        d = 1;
        prev_stall = 1'b0;
        stall_mode = stall;
        i_data_valid = 1'b1;
        i_ifft_ready = 1'b1;
        i_data = {d[15:0], 16'(d + 1000)};
        i_num_sym = 8'(n);
        i_start = 1'b1;
        tick();
        start_cyc = cyc;
        i_start = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (n_done > 0) break;
            if (abort_at >= 0 && cap_dat.size() == abort_at) break;
            if (k == mid_start) begin
                i_start = 1'b1;
                i_num_sym = 8'd9;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_start = 1'b0;
        stall_mode = 1'b0;
        if (abort_at < 0) begin
            chk($sformatf("n%0d done seen", n), n_done, 1);
            tick();
            tick();
        end
    endtask

    task automatic verify(input string tag, input int n);
        int dd, mism, s, b;
        logic [31:0] e;
        bit neg;
        chk($sformatf("%s count", tag), cap_dat.size(), n * 64);
        dd = 1;
        mism = 0;
        for (int i = 0; i < cap_dat.size(); i++) begin
            s = i / 64;
            b = i % 64;
            if (b == 0 || (b >= 27 && b <= 37)) begin
                e = 32'h0;
            end else if (b == 7 || b == 21 || b == 43 || b == 57) begin
                neg = pol(s) ^ (b == 57);
                e = {(neg ? 16'hC000 : 16'h4000), 16'h0000};
            end else begin
                e = {16'(dd), 16'(dd + 1000)};
                dd++;
            end
            if (cap_dat[i] !== e || cap_bin[i] != b) mism++;
        end
        chk($sformatf("%s seq mismatches", tag), mism, 0);
        chk($sformatf("%s sym_start", tag), n_start, n);
        chk($sformatf("%s sym_last", tag), n_last, n);
        chk($sformatf("%s protocol", tag), viol, 0);
        chk($sformatf("%s done once", tag), n_done, (n > 0) ? 1 : 0);
    endtask

    task automatic apply_table(input string tag, input int n);
        int idx;
        logic [31:0] act;
        for (int t = 0; t < 18; t++) begin
            if (tbl[t].sym < n) begin
                idx = tbl[t].sym * 64 + tbl[t].bin;
                act = (idx < cap_dat.size()) ? cap_dat[idx] : 32'hxxxxxxxx;
                chk($sformatf("%s tbl s%0d b%0d", tag, tbl[t].sym, tbl[t].bin), act, {tbl[t].ei, tbl[t].eq});
            end
        end
    endtask

    task automatic idle_checks(input string tag);
        chk($sformatf("%s busy", tag), o_busy, 0);
        chk($sformatf("%s valid", tag), o_sym_valid, 0);
        chk($sformatf("%s data_ready", tag), o_data_ready, 0);
        chk($sformatf("%s bin", tag), o_bin_index, 0);
        chk($sformatf("%s done", tag), o_done, 0);
        chk($sformatf("%s sym_data", tag), o_sym_data, 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0,  16'h0000, 16'h0000};
        tbl[1]  = '{0, 1,  16'd1,    16'd1001};
        tbl[2]  = '{0, 6,  16'd6,    16'd1006};
        tbl[3]  = '{0, 7,  16'h4000, 16'h0000};
        tbl[4]  = '{0, 8,  16'd7,    16'd1007};
        tbl[5]  = '{0, 21, 16'h4000, 16'h0000};
        tbl[6]  = '{0, 27, 16'h0000, 16'h0000};
        tbl[7]  = '{0, 37, 16'h0000, 16'h0000};
        tbl[8]  = '{0, 38, 16'd25,   16'd1025};
        tbl[9]  = '{0, 43, 16'h4000, 16'h0000};
        tbl[10] = '{0, 57, 16'hC000, 16'h0000};
        tbl[11] = '{0, 63, 16'd48,   16'd1048};
        tbl[12] = '{1, 1,  16'd49,   16'd1049};
        tbl[13] = '{3, 21, 16'h4000, 16'h0000};
        tbl[14] = '{4, 7,  16'hC000, 16'h0000};
        tbl[15] = '{4, 57, 16'h4000, 16'h0000};
        tbl[16] = '{4, 63, 16'd240,  16'd1240};
        tbl[17] = '{5, 21, 16'hC000, 16'h0000};

        i_rst_n = 1'b0;
        i_enable = 1'b1;
        i_start = 1'b0;
        i_num_sym = 8'd0;
        i_data = 32'h1234_5678;
        i_data_valid = 1'b1;
        i_ifft_ready = 1'b1;
        #12;
        idle_checks("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick();

        // Single symbol, clean flow.
        run_burst(1, 1'b0, -1, -1);
        verify("b1", 1);
        apply_table("b1", 1);
        chk("b1 done timing", done_cyc, last_acc_cyc + 1);

        // Six symbols clean, then with stalls; the stalled stream must match.
        run_burst(6, 1'b0, -1, -1);
        verify("b6", 6);
        apply_table("b6", 6);
        ref_dat = cap_dat;
        run_burst(6, 1'b1, -1, -1);
        verify("b6s", 6);
        apply_table("b6s", 6);
        begin
            int mism = 0;
            if (ref_dat.size() != cap_dat.size()) mism++;
            for (int i = 0; i < ref_dat.size() && i < cap_dat.size(); i++)
                if (ref_dat[i] !== cap_dat[i]) mism++;
            chk("stall vs clean", mism, 0);
        end

        // Zero-length burst.
        run_burst(0, 1'b0, -1, -1);
        chk("n0 outputs", cap_dat.size(), 0);
        chk("n0 done timing", done_cyc, start_cyc + 1);
        chk("n0 done once", n_done, 1);

        // Start pulse mid-burst is ignored.
        run_burst(2, 1'b0, 50, -1);
        verify("mid", 2);

        // Enable dropped at bin 30 of symbol 2.
        run_burst(4, 1'b0, -1, 2 * 64 + 30);
        chk("en abort bin", o_bin_index, 30);
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        #1;
        idle_checks("en drop");
        tick();
        tick();
        chk("en no done", n_done, 0);
        run_burst(1, 1'b0, -1, -1);
        verify("en restart", 1);
        apply_table("en restart", 1);

        // Async reset at the same point.
        run_burst(4, 1'b0, -1, 2 * 64 + 30);
        chk("rst abort bin", o_bin_index, 30);
        i_rst_n = 1'b0;
        #1;
        idle_checks("rst drop");
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("rst no done", n_done, 0);
        run_burst(1, 1'b0, -1, -1);
        verify("rst restart", 1);
        apply_table("rst restart", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
